mem_sweep_ctrl: RTL and testbench

Test controller that sits directly upstream of the block-RAM `memory` stage. It drives that stage's read and write ports and consumes its registered `dout`. On command it fills the memory with a deterministic address-derived pattern and/or reads every location back, comparing each word against the same pattern. It reports the mismatch count and the first failing address, so memory contents can be checked after bitstream reinitialisation.

---
 rtl/mem_sweep_pkg.sv | 20 ++
 rtl/mem_sweep_ctrl_if.sv | 26 ++
 rtl/mem_sweep_cmp.sv | 61 ++++++
 rtl/mem_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the memory sweep controller.
// The pattern is derived from the address and a per-run seed.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CHECK,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

    // Callers truncate the result to the memory data width.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/mem_sweep_ctrl_if.sv
// Read/write port bundle between the sweep controller and the block-RAM stage.
interface mem_sweep_ctrl_if #(
    parameter int WID_MEM = 2
);
    logic [31:0]        mem_raddr;
    logic [31:0]        mem_waddr;
    logic               mem_we;
    logic [WID_MEM-1:0] mem_din;
    logic [WID_MEM-1:0] mem_dout;

    modport master (
        output mem_raddr,
        output mem_waddr,
        output mem_we,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_raddr,
        input  mem_waddr,
        input  mem_we,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_sweep_cmp.sv
// Compare pipeline: registers the expected word alongside each read, then checks the
// returning data, counting mismatches (saturating) and capturing the first failing address.
module mem_sweep_cmp
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               flush,
    input  logic               issue,
    input  logic [WID_MEM-1:0] exp,
    input  logic [CNT_W-1:0]   addr,
    input  logic [WID_MEM-1:0] dout,
    output logic [31:0]        err_count,
    output logic               first_err_valid,
    output logic [31:0]        first_err_addr
);

    logic               cmp_v_q;
    logic [WID_MEM-1:0] exp_q;
    logic [CNT_W-1:0]   addr_q;
    logic               mismatch;

    // A flush drops the compare in flight without touching the accumulated results.
    assign mismatch = cmp_v_q && !flush && (dout != exp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_v_q         <= 1'b0;
            exp_q           <= '0;
            addr_q          <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (clear) begin
            cmp_v_q         <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            cmp_v_q <= issue && !flush;
            if (issue) begin
                exp_q  <= exp;
                addr_q <= addr;
            end
            if (mismatch) begin
                if (err_count != ERR_SAT) begin
                    err_count <= err_count + 32'd1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= 32'(addr_q);
                end
            end
        end
    end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Memory sweep controller: optional fill pass with an address-derived pattern followed by
// a full read-back check, reporting mismatch count and first failing address.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM    = 2,
    parameter int DEPTH_MEM  = 32768,
    localparam int CNT_W     = $clog2(DEPTH_MEM) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               do_fill,
    input  logic [WID_MEM-1:0] seed,
    input  logic               abort,
    mem_sweep_ctrl_if.master   mem,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [31:0]        err_count,
    output logic               first_err_valid,
    output logic [31:0]        first_err_addr,
    output logic               aborted
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WID_MEM-1:0] seed_q, seed_d;
    logic               pass_q, pass_d;
    logic               aborted_q, aborted_d;
    logic [31:0]        waddr_q, raddr_q;
    logic [WID_MEM-1:0] din_q;
    logic [WID_MEM-1:0] pat_w;
    logic               last;
    logic               clear, issue, flush;

    assign pat_w = WID_MEM'(pat(32'(cnt_q), 32'(seed_q)));
    assign last  = (cnt_q == CNT_W'(DEPTH_MEM - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;
        clear     = 1'b0;
        issue     = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    seed_d    = seed;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = do_fill ? FILL : CHECK;
                end
            end
            FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                issue = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                pass_d  = (err_count == 32'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything except the idle-state start decision.
        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            issue     = 1'b0;
            flush     = 1'b1;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seed_q    <= '0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seed_q    <= seed_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
            if (state_q == FILL) begin
                waddr_q <= 32'(cnt_q);
                din_q   <= pat_w;
            end
            if (state_q == CHECK) begin
                raddr_q <= 32'(cnt_q);
            end
        end
    end

    // Address ports follow the counter while active and hold their last value otherwise.
    always_comb begin
        mem.mem_we    = (state_q == FILL);
        mem.mem_waddr = (state_q == FILL) ? 32'(cnt_q) : waddr_q;
        mem.mem_din   = (state_q == FILL) ? pat_w : din_q;
        mem.mem_raddr = (state_q == CHECK) ? 32'(cnt_q) : raddr_q;
        busy          = (state_q == FILL) || (state_q == CHECK) || (state_q == DRAIN);
        done          = (state_q == DONE);
        pass          = (state_q == DONE) ? (err_count == 32'd0) : pass_q;
        aborted       = aborted_q;
    end

    mem_sweep_cmp #(
        .WID_MEM(WID_MEM),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .flush          (flush),
        .issue          (issue),
        .exp            (pat_w),
        .addr           (cnt_q),
        .dout           (mem.mem_dout),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench for mem_sweep_ctrl with a 1-cycle-latency memory model.
module tb_mem_sweep_ctrl;

    localparam int W = 2;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         do_fill = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] seed = '0;
    logic         busy, done, pass, first_err_valid, aborted;
    logic [31:0]  err_count, first_err_addr;

    mem_sweep_ctrl_if #(.WID_MEM(W)) mif ();

    mem_sweep_ctrl #(
        .WID_MEM  (W),
        .DEPTH_MEM(D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .do_fill        (do_fill),
        .seed           (seed),
        .abort          (abort),
        .mem            (mif),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr),
        .aborted        (aborted)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem     [D];
    logic [W-1:0] pre_mem [D];
    logic         pre_en = 1'b0;
    logic         stuck0 = 1'b0;
    logic [W-1:0] rd_q;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) mem <= pre_mem;
        else if (mif.mem_we) mem[mif.mem_waddr[3:0]] <= mif.mem_din;
        rd_q <= mem[mif.mem_raddr[3:0]];
    end

    assign mif.mem_dout = stuck0 ? (rd_q | 2'b01) : rd_q;

    typedef struct {
        bit          is_abort;
        logic [31:0] err;
        logic        fev;
        logic [31:0] fea;
        logic        pass;
        int          cyc;
    } res_t;

    typedef struct {
        logic [31:0]  a;
        logic [W-1:0] d;
    } wr_t;

    res_t sbq[$];
    wr_t  wq[$];
    res_t mr;
    wr_t  mw;
    int   checks = 0;
    int   errors = 0;
    logic aborted_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: pops expected writes and run results whenever the DUT presents them.
    always @(negedge clk) begin
        if (mif.mem_we) begin
            if (wq.size() == 0) fail_now("unexpected_write");
            else begin
                mw = wq.pop_front();
                check("waddr", mif.mem_waddr, mw.a);
                check("wdata", 32'(mif.mem_din), 32'(mw.d));
            end
        end
        if (done || (aborted && !aborted_prev)) begin
            if (sbq.size() == 0) fail_now("unexpected_result");
            else begin
                mr = sbq.pop_front();
                check("done_vs_abort", 32'(done), 32'(!mr.is_abort));
                check("err_count", err_count, mr.err);
                check("first_err_valid", 32'(first_err_valid), 32'(mr.fev));
                check("first_err_addr", first_err_addr, mr.fea);
                check("pass", 32'(pass), 32'(mr.pass));
                check("result_cycle", 32'(cyc), 32'(mr.cyc));
                if (mr.is_abort) begin
                    check("abort_we", 32'(mif.mem_we), 32'd0);
                    check("abort_busy", 32'(busy), 32'd0);
                end
            end
        end
        aborted_prev = aborted;
    end

    task automatic push_res(input bit ab, input int lat, input logic [31:0] e_err,
                            input logic e_fev, input logic [31:0] e_fea, input logic e_pass);
        res_t r;
        r.is_abort = ab;
        r.err      = e_err;
        r.fev      = e_fev;
        r.fea      = e_fea;
        r.pass     = e_pass;
        r.cyc      = cyc + 1 + lat;
        sbq.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input bit fill, input logic [W-1:0] s, input logic ab,
                         input logic [31:0] e_err, input logic e_fev,
                         input logic [31:0] e_fea, input logic e_pass);
        wr_t w;
        push_res(1'b0, fill ? 2 * D + 1 : D + 1, e_err, e_fev, e_fea, e_pass);
        if (fill) begin
            for (int a = 0; a < D; a++) begin
                w.a = 32'(a);
                w.d = W'(a) ^ s;
                wq.push_back(w);
            end
        end
        start   = 1'b1;
        do_fill = fill;
        seed    = s;
        abort   = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic preload(input logic [W-1:0] s);
        for (int a = 0; a < D; a++) pre_mem[a] = W'(a) ^ s;
    endtask

    task automatic commit_preload();
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", err_count, 32'd0);
        check("rst_we", 32'(mif.mem_we), 32'd0);
        check("rst_waddr", mif.mem_waddr, 32'd0);
        check("rst_raddr", mif.mem_raddr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: fill + check, seed 1, fault-free; abort together with start is ignored.
        issue(1'b1, 2'b01, 1'b1, 32'd0, 1'b0, 32'd0, 1'b1);
        wait_done();

        // 2: check only against a preload with two corrupted words.
        preload(2'b00);
        pre_mem[5] = 2'b11;
        pre_mem[9] = 2'b00;
        commit_preload();
        issue(1'b0, 2'b00, 1'b0, 32'd2, 1'b1, 32'd5, 1'b0);
        wait_done();

        // 3: bit 0 stuck at 1 fails every even address.
        stuck0 = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'd8, 1'b1, 32'd0, 1'b0);
        wait_done();
        stuck0 = 1'b0;

        // 4: abort on the 5th check cycle; error at 1 counted, error at 3 still in flight.
        preload(2'b00);
        pre_mem[1] = 2'b10;
        pre_mem[3] = 2'b00;
        commit_preload();
        push_res(1'b1, 5, 32'd1, 1'b1, 32'd1, 1'b0);
        start   = 1'b1;
        do_fill = 1'b0;
        seed    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (40) @(negedge clk);

        // 5: repeated start pulses (with a different seed) during fill are ignored.
        issue(1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            seed  = 2'b10;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        wait_done();

        // 6: asynchronous reset mid-fill, then a clean rerun.
        issue(1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_we", 32'(mif.mem_we), 32'd0);
        check("arst_waddr", mif.mem_waddr, 32'd0);
        check("arst_din", 32'(mif.mem_din), 32'd0);
        check("arst_raddr", mif.mem_raddr, 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_aborted", 32'(aborted), 32'd0);
        sbq.delete();
        wq.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b1, 2'b01, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        check("writes_drained", 32'(wq.size()), 32'd0);
        check("results_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
